// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave that streams a command/address/data frame into a word-addressed memory.
// Each write strobes one clk after the 8th-bit sample; no backpressure, so the memory must accept every write.
module spi_mem_loader #(
  parameter int M  = 320,
  parameter int N  = 8,
  parameter int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic          mosi,
  output logic [N-1:0]  mem_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          busy,
  output logic          err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] ADDR_HI = 3'd2;
  localparam logic [2:0] ADDR_LO = 3'd3;
  localparam logic [2:0] DATA    = 3'd4;
  localparam logic [2:0] IGNORE  = 3'd5;

  localparam logic [7:0] CMD_WRITE = 8'hA5;

  logic [1:0]    sclk_sync;
  logic [1:0]    cs_sync;
  logic [1:0]    mosi_sync;
  logic          sclk_d;
  logic          cs_d;
  logic [2:0]    state;
  logic [N-1:0]  shift_reg;
  logic [2:0]    bit_cnt;
  logic [7:0]    addr_hi;
  logic [AW-1:0] ptr;

  logic          sclk_rise;
  logic          cs_fall;
  logic          cs_rise;
  logic          byte_done;
  logic [N-1:0]  byte_val;
  logic [AW-1:0] start_addr;
  logic          start_ok;
  logic [AW-1:0] ptr_next;

  assign sclk_rise  = sclk_sync[1] & ~sclk_d;
  assign cs_fall    = cs_d & ~cs_sync[1];
  assign cs_rise    = ~cs_d & cs_sync[1];
  assign byte_done  = sclk_rise && (bit_cnt == 3'd7);
  assign byte_val   = {shift_reg[N-2:0], mosi_sync[1]};
  assign start_addr = AW'({addr_hi, byte_val});
  assign start_ok   = (32'(start_addr) < M);
  assign ptr_next   = (ptr == AW'(M - 1)) ? '0 : ptr + AW'(1);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      addr_hi   <= '0;
      ptr       <= '0;
      mem_data  <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      err       <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
      mem_we    <= 1'b0;

      if (state == IDLE) begin
        if (cs_fall) begin
          state   <= CMD;
          bit_cnt <= '0;
          err     <= 1'b0;
        end
      end else begin
        if (sclk_rise) begin
          shift_reg <= byte_val;
          bit_cnt   <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            CMD: begin
              if (byte_val == CMD_WRITE) begin
                state <= ADDR_HI;
              end else begin
                state <= IGNORE;
                err   <= 1'b1;
              end
            end
            ADDR_HI: begin
              addr_hi <= byte_val;
              state   <= ADDR_LO;
            end
            ADDR_LO: begin
              if (start_ok) begin
                ptr   <= start_addr;
                state <= DATA;
              end else begin
                state <= IGNORE;
                err   <= 1'b1;
              end
            end
            DATA: begin
              mem_data <= byte_val;
              mem_addr <= ptr;
              mem_we   <= 1'b1;
              ptr      <= ptr_next;
            end
            default: ;
          endcase
        end
        // Frame end overrides the state update above, but a write issued on this cycle still stands.
        if (cs_rise) begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_loader.sv
// Scoreboard bench for spi_mem_loader: expected writes are queued as frames are driven and retired by a write monitor.
module tb_spi_mem_loader;

  localparam int M  = 320;
  localparam int N  = 8;
  localparam int AW = $clog2(M);

  typedef struct packed {
    logic [N-1:0]  data;
    logic [AW-1:0] addr;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          sclk;
  logic          cs_n;
  logic          mosi;
  logic [N-1:0]  mem_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          busy;
  logic          err;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  logic we_prev = 1'b0;

  spi_mem_loader #(.M(M), .N(N), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .mem_data (mem_data),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      checks++;
      if (we_prev === 1'b1) begin
        errors++;
        $display("FAIL we_pulse_width: mem_we high two clks in a row, required single-clk pulse");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got data=%h addr=%0d, required no write", mem_data, mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (mem_data !== e.data || mem_addr !== e.addr) begin
          errors++;
          $display("FAIL write_value: got data=%h addr=%0d, required data=%h addr=%0d",
                   mem_data, mem_addr, e.data, e.addr);
        end
      end
    end
    we_prev = mem_we;
  end

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #20 sclk = 1'b1;
      #20 sclk = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    #40;
  endtask

  task automatic frame_end();
    #40 cs_n = 1'b1;
    #60;
  endtask

  task automatic expect_wr(input logic [7:0] d, input int a);
    wr_t e;
    e.data = d;
    e.addr = AW'(a);
    exp_q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (mem_we !== 1'b0 || mem_data !== '0 || mem_addr !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s: got we=%b data=%h addr=%0d busy=%b err=%b, required all 0",
               tag, mem_we, mem_data, mem_addr, busy, err);
    end
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected writes missing, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_flags(input string tag, input logic exp_busy, input logic exp_err);
    checks++;
    if (busy !== exp_busy || err !== exp_err) begin
      errors++;
      $display("FAIL %s: got busy=%b err=%b, required busy=%b err=%b", tag, busy, err, exp_busy, exp_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    #33;
    check_idle_outputs("reset_state");
    reset = 1'b0;
    #40;
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_basic();
    expect_wr(8'h11, 5);
    expect_wr(8'h22, 6);
    expect_wr(8'h33, 7);
    frame_start();
    check_flags("basic_busy_in_frame", 1'b1, 1'b0);
    spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h05);
    spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33);
    frame_end();
    check_drained("basic_writes");
    check_flags("basic_flags_after", 1'b0, 1'b0);
    checks++;
    if (mem_data !== 8'h33 || mem_addr !== AW'(7)) begin
      errors++;
      $display("FAIL basic_hold: got data=%h addr=%0d, required data=33 addr=7", mem_data, mem_addr);
    end
  endtask

  task automatic test_bad_cmd();
    frame_start();
    spi_byte(8'h5A); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'hFF);
    check_flags("bad_cmd_err_in_frame", 1'b1, 1'b1);
    frame_end();
    check_flags("bad_cmd_err_sticky", 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    expect_wr(8'hAA, 319);
    expect_wr(8'hBB, 0);
    expect_wr(8'hCC, 1);
    frame_start();
    check_flags("wrap_err_cleared", 1'b1, 1'b0);
    spi_byte(8'hA5); spi_byte(8'h01); spi_byte(8'h3F);
    spi_byte(8'hAA); spi_byte(8'hBB); spi_byte(8'hCC);
    frame_end();
    check_drained("wrap_writes");
    check_flags("wrap_flags_after", 1'b0, 1'b0);
  endtask

  task automatic test_bad_addr();
    frame_start();
    spi_byte(8'hA5); spi_byte(8'h01); spi_byte(8'h40);
    spi_byte(8'hDE); spi_byte(8'hAD);
    frame_end();
    check_flags("bad_addr_err", 1'b0, 1'b1);
  endtask

  task automatic test_partial();
    expect_wr(8'h77, 2);
    frame_start();
    spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h02); spi_byte(8'h77);
    spi_bits(8'hE8, 5);
    frame_end();
    check_drained("partial_writes");
    check_flags("partial_flags_after", 1'b0, 1'b0);
    checks++;
    if (mem_addr !== AW'(2) || mem_data !== 8'h77) begin
      errors++;
      $display("FAIL partial_hold: got data=%h addr=%0d, required data=77 addr=2", mem_data, mem_addr);
    end
  endtask

  task automatic test_reset_midframe();
    frame_start();
    spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h00);
    spi_bits(8'hC3, 3);
    mosi = 1'b0;
    #10 reset = 1'b1;
    #20;
    check_idle_outputs("midframe_reset_state");
    reset = 1'b0;
    #10 sclk = 1'b1;
    #20 sclk = 1'b0;
    spi_bits(8'h30, 4);
    frame_end();
    check_idle_outputs("midframe_no_write");
  endtask

  task automatic test_back_to_back();
    expect_wr(8'h5C, 16);
    expect_wr(8'h5D, 17);
    expect_wr(8'h00, 18);
    expect_wr(8'hFF, 19);
    frame_start();
    spi_byte(8'hA5); spi_byte(8'h00); spi_byte(8'h10);
    spi_byte(8'h5C); spi_byte(8'h5D); spi_byte(8'h00); spi_byte(8'hFF);
    frame_end();
    check_drained("back_to_back_writes");
    check_flags("back_to_back_flags", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_cmd();
    test_wrap();
    test_bad_addr();
    test_partial();
    test_reset_midframe();
    test_back_to_back();
    #50;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
